// File: rtl/ovs_edge_timestamper_pkg.sv
// Shared types, defaults and sizing helper for the oversampled edge timestamper.
package ovs_detector_pkg;

  localparam int unsigned OVS_DEFAULT_WIDTH   = 64;
  localparam int unsigned OVS_DEFAULT_TS_BITS = 32;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  // Ceiling log base 4; also the number of radix-4 search levels for a word.
  function automatic int unsigned clog4(input int unsigned value);
    int unsigned r;
    longint unsigned p;
    r = 0;
    p = 1;
    for (int i = 0; i < 16; i++) begin
      if (p < 64'(value)) begin
        p = p << 2;
        r = r + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ovs_edge_timestamper_if.sv
// Word-in / event-out bundle between the ISERDES side and the measurement logic.
interface ovs_edge_timestamper_if
  import ovs_detector_pkg::*;
#(
  parameter int unsigned WIDTH   = OVS_DEFAULT_WIDTH,
  parameter int unsigned TS_BITS = OVS_DEFAULT_TS_BITS
) ();

  localparam int unsigned IDX_W = 2 * clog4(WIDTH);

  logic [WIDTH-1:0]   PARALLEL_IN;
  logic [1:0]         EDGE_MODE;
  logic               CHANGED_FLAG;
  logic [IDX_W-1:0]   CHANGED_BIT;
  logic               EDGE_RISING;
  logic [TS_BITS-1:0] TIMESTAMP;
  logic               GLITCH_FLAG;

  modport master (
    output PARALLEL_IN, EDGE_MODE,
    input  CHANGED_FLAG, CHANGED_BIT, EDGE_RISING, TIMESTAMP, GLITCH_FLAG
  );

  modport slave (
    input  PARALLEL_IN, EDGE_MODE,
    output CHANGED_FLAG, CHANGED_BIT, EDGE_RISING, TIMESTAMP, GLITCH_FLAG
  );

endinterface

// File: rtl/ovs_edge_timestamper_search_level.sv
// One radix-4 search level: select register picks the first quarter whose end
// differs from the line state, mux register forwards it and extends the index.
module ovs_radix4_search_level
  import ovs_detector_pkg::*;
#(
  parameter int unsigned CHUNK_W = 64,
  parameter int unsigned IDX_W   = 6,
  parameter int unsigned CNT_W   = 26
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CHUNK_W-1:0]   i_chunk,
  input  logic                 i_last,
  input  logic                 i_report,
  input  logic                 i_rising,
  input  logic                 i_glitch,
  input  logic [IDX_W-1:0]     i_idx,
  input  logic [CNT_W-1:0]     i_cnt,
  output logic [CHUNK_W/4-1:0] o_chunk,
  output logic                 o_last,
  output logic                 o_report,
  output logic                 o_rising,
  output logic                 o_glitch,
  output logic [IDX_W-1:0]     o_idx,
  output logic [CNT_W-1:0]     o_cnt
);

  localparam int unsigned Q = CHUNK_W / 4;

  logic [1:0]         w_sel;
  logic [Q-1:0]       w_quarter;
  logic [CHUNK_W-1:0] r_chunk;
  logic [1:0]         r_sel;
  logic               r_last;
  logic               r_report;
  logic               r_rising;
  logic               r_glitch;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;

  // Scan downwards so the lowest differing quarter wins; default to the top one.
  always_comb begin
    w_sel = 2'd3;
    for (int j = 2; j >= 0; j--) begin
      if (i_chunk[(j+1)*Q-1] != i_last) w_sel = 2'(j);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chunk  <= '0;
      r_sel    <= '0;
      r_last   <= 1'b0;
      r_report <= 1'b0;
      r_rising <= 1'b0;
      r_glitch <= 1'b0;
      r_idx    <= '0;
      r_cnt    <= '0;
    end else begin
      r_chunk  <= i_chunk;
      r_sel    <= w_sel;
      r_last   <= i_last;
      r_report <= i_report;
      r_rising <= i_rising;
      r_glitch <= i_glitch;
      r_idx    <= i_idx;
      r_cnt    <= i_cnt;
    end
  end

  always_comb begin
    case (r_sel)
      2'd0:    w_quarter = r_chunk[Q-1:0];
      2'd1:    w_quarter = r_chunk[2*Q-1:Q];
      2'd2:    w_quarter = r_chunk[3*Q-1:2*Q];
      default: w_quarter = r_chunk[4*Q-1:3*Q];
    endcase
  end

  // Event fields are zeroed when nothing is reported, so the last level drives outputs directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_chunk  <= '0;
      o_last   <= 1'b0;
      o_report <= 1'b0;
      o_rising <= 1'b0;
      o_glitch <= 1'b0;
      o_idx    <= '0;
      o_cnt    <= '0;
    end else begin
      o_chunk  <= w_quarter;
      o_last   <= r_last;
      o_report <= r_report;
      o_rising <= r_rising & r_report;
      o_glitch <= r_glitch;
      o_idx    <= r_report ? IDX_W'({r_idx, r_sel}) : '0;
      o_cnt    <= r_report ? r_cnt : '0;
    end
  end

endmodule

// File: rtl/ovs_edge_timestamper.sv
// Oversampled edge locator/timestamper, 2*LEVELS cycles latency, one word per cycle.
// Define OVS_EDGE_TIMESTAMPER_GLITCH_DET_EN to build the multi-transition (glitch) detector.
module ovs_edge_timestamper
  import ovs_detector_pkg::*;
#(
  parameter int unsigned WIDTH   = OVS_DEFAULT_WIDTH,
  parameter int unsigned TS_BITS = OVS_DEFAULT_TS_BITS
) (
  input logic                  CLK_PARALLEL,
  input logic                  RESET,
  ovs_edge_timestamper_if.slave bus
);

  localparam int unsigned LEVELS = clog4(WIDTH);
  localparam int unsigned IDX_W  = 2 * LEVELS;
  localparam int unsigned CNT_W  = TS_BITS - IDX_W;

  logic             r_last;
  logic [CNT_W-1:0] r_word_cnt;
  edge_mode_t       w_mode;
  logic             w_rising;
  logic             w_report;
  logic             w_glitch;

  logic [WIDTH-1:0] w_chunk  [LEVELS+1];
  logic             w_last_p [LEVELS+1];
  logic             w_rep_p  [LEVELS+1];
  logic             w_rise_p [LEVELS+1];
  logic             w_gl_p   [LEVELS+1];
  logic [IDX_W-1:0] w_idx_p  [LEVELS+1];
  logic [CNT_W-1:0] w_cnt_p  [LEVELS+1];

  // Line state and word counter track every cycle, independent of EDGE_MODE.
  always_ff @(posedge CLK_PARALLEL) begin
    if (RESET) begin
      r_last     <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      r_last     <= bus.PARALLEL_IN[WIDTH-1];
      r_word_cnt <= r_word_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_mode   = edge_mode_t'(bus.EDGE_MODE);
    w_rising = bus.PARALLEL_IN[WIDTH-1];
    w_report = (w_rising ^ r_last) &
               ((w_mode == EDGE_BOTH) |
                (w_rising ? (w_mode == EDGE_RISE) : (w_mode == EDGE_FALL)));
  end

`ifdef OVS_EDGE_TIMESTAMPER_GLITCH_DET_EN
  localparam int unsigned POP_W = IDX_W + 1;
  logic [WIDTH-1:0] w_trans;
  logic [POP_W-1:0] w_trans_cnt;

  always_comb begin
    w_trans     = bus.PARALLEL_IN ^ {bus.PARALLEL_IN[WIDTH-2:0], r_last};
    w_trans_cnt = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_trans_cnt = w_trans_cnt + POP_W'(w_trans[i]);
    end
    w_glitch = (w_trans_cnt >= POP_W'(2));
  end
`else
  assign w_glitch = 1'b0;
`endif

  // Level 0 select register doubles as the capture stage for the incoming word.
  assign w_chunk[0]  = bus.PARALLEL_IN;
  assign w_last_p[0] = r_last;
  assign w_rep_p[0]  = w_report;
  assign w_rise_p[0] = w_rising;
  assign w_gl_p[0]   = w_glitch;
  assign w_idx_p[0]  = '0;
  assign w_cnt_p[0]  = r_word_cnt;

  for (genvar k = 0; k < int'(LEVELS); k++) begin : g_level
    localparam int unsigned CHUNK_W = WIDTH >> (2 * k);
    logic [CHUNK_W/4-1:0] w_next_chunk;

    ovs_radix4_search_level #(
      .CHUNK_W (CHUNK_W),
      .IDX_W   (IDX_W),
      .CNT_W   (CNT_W)
    ) u_level (
      .clk      (CLK_PARALLEL),
      .rst      (RESET),
      .i_chunk  (w_chunk[k][CHUNK_W-1:0]),
      .i_last   (w_last_p[k]),
      .i_report (w_rep_p[k]),
      .i_rising (w_rise_p[k]),
      .i_glitch (w_gl_p[k]),
      .i_idx    (w_idx_p[k]),
      .i_cnt    (w_cnt_p[k]),
      .o_chunk  (w_next_chunk),
      .o_last   (w_last_p[k+1]),
      .o_report (w_rep_p[k+1]),
      .o_rising (w_rise_p[k+1]),
      .o_glitch (w_gl_p[k+1]),
      .o_idx    (w_idx_p[k+1]),
      .o_cnt    (w_cnt_p[k+1])
    );

    assign w_chunk[k+1] = WIDTH'(w_next_chunk);
  end

  assign bus.CHANGED_FLAG = w_rep_p[LEVELS];
  assign bus.CHANGED_BIT  = w_idx_p[LEVELS];
  assign bus.EDGE_RISING  = w_rise_p[LEVELS];
  assign bus.TIMESTAMP    = {w_cnt_p[LEVELS], w_idx_p[LEVELS]};
  assign bus.GLITCH_FLAG  = w_gl_p[LEVELS];

endmodule

// File: doc/ovs_edge_timestamper.md
Name: ovs_edge_timestamper

Overview:
- Parametrised successor to the 64-bit oversampled ISERDES change detector.
- Takes one WIDTH-bit oversampled word per CLK_PARALLEL cycle, in time order with bit 0 earliest.
- Finds the first sample that differs from the previous line state, then emits a pipelined event carrying:
  - edge polarity
  - bit position
  - an absolute sample-resolution timestamp
- Sits between the ISERDES deserializer and the theremin period/phase measurement logic, with runtime edge-mode selection.

Parameters:
- WIDTH, 64, samples per parallel word; must be a power of 4 (16, 64, 256).
- TS_BITS, 32, total timestamp width; must exceed log2(WIDTH).
- LEVELS, log2(WIDTH)/2 (derived localparam), number of radix-4 search levels.

Ports:
- CLK_PARALLEL  in  1  parallel-domain clock (200 MHz).
- RESET  in  1  synchronous reset, active-high, synchronous to CLK_PARALLEL.
- PARALLEL_IN  in  WIDTH  oversampled word, bit 0 = earliest sample.
- EDGE_MODE  in  2  00 none, 01 rising only, 10 falling only, 11 both.
- CHANGED_FLAG  out  1  one-cycle pulse per reported edge.
- CHANGED_BIT  out  log2(WIDTH)  index of first changed sample; 0 when flag low.
- EDGE_RISING  out  1  1 = rising (0->1), 0 = falling; 0 when flag low.
- TIMESTAMP  out  TS_BITS  {word_counter, CHANGED_BIT}; 0 when flag low.
- GLITCH_FLAG  out  1  word contained ≥2 transitions (optional feature; tied 0 when compiled out).

Behaviour:
- Reset values:
  - All outputs 0, all pipeline registers 0.
  - last_state = 0 and word_counter = 0.
- last_state:
  - Each non-reset cycle, last_state <= PARALLEL_IN[WIDTH-1].
  - Updated regardless of EDGE_MODE.
- Stage 0 (registered, cycle 1):
  - change = PARALLEL_IN[WIDTH-1] ^ last_state.
  - rising = PARALLEL_IN[WIDTH-1].
  - report = change & EDGE_MODE[rising ? 0 : 1].
  - EDGE_MODE is sampled in the same cycle as the word it applies to.
  - Capture the word, last_state and word_counter with it.
- Search levels, one per radix-4 level; each level takes two registered stages:
  - Select stage: pick the lowest quarter q whose top bit differs from the delayed last_state; q = 3 if none do.
  - Mux stage: forward that quarter; append q to the accumulated index, MSBs first.
- Final stage: gate CHANGED_BIT, EDGE_RISING and TIMESTAMP with report.
- Latency:
  - Total is exactly 2*LEVELS cycles from PARALLEL_IN sample to CHANGED_FLAG.
  - That is 6 for WIDTH=64 and 4 for WIDTH=16.
  - Throughput: one word per cycle, no stalls, no backpressure.
- Multiple transitions in one word: only the first transition differing from last_state is located. Even transition counts (word ends equal to last_state) report no edge.
- word_counter:
  - Width TS_BITS - log2(WIDTH); increments every non-reset cycle.
  - Wraps modulo 2^(TS_BITS-log2(WIDTH)) silently.
  - TIMESTAMP uses the counter value captured with the word, not the output-cycle value.
- Reset mid-operation: the pipeline is flushed; no CHANGED_FLAG for any word in flight or presented during RESET. The first word after reset compares against last_state = 0.
- EDGE_MODE = 00: no flags are generated; last_state and word_counter keep tracking.

Optional Feature:
- Macro: OVS_EDGE_TIMESTAMPER_GLITCH_DET_EN.
- Defined:
  - Stage 0 computes t = PARALLEL_IN ^ {PARALLEL_IN[WIDTH-2:0], last_state} and glitch = (popcount(t) ≥ 2).
  - glitch is delayed alongside the word; GLITCH_FLAG pulses with the same latency as CHANGED_FLAG.
  - It is independent of EDGE_MODE and of report.
- Undefined: GLITCH_FLAG is constant 0 and no popcount logic is synthesised.

Decomposition:
- Package ovs_detector_pkg:
  - edge_mode_t enum: EDGE_NONE, EDGE_RISE, EDGE_FALL, EDGE_BOTH.
  - function clog4.
  - localparam OVS_DEFAULT_WIDTH = 64.
- Sub-module ovs_radix4_search_level:
  - One select+mux register pair, parametrised by input chunk width.
  - Passes through last_state, report, rising, index and timestamp.
  - The top level instantiates it LEVELS times in a generate loop.

Test Plan:
- Reset, then WIDTH=64, EDGE_MODE=11; cycle 0 word 0x0, cycle 1 word 0xFFFF_FFFF_FFFF_FFF0 -> 6 cycles after cycle 1: CHANGED_FLAG=1, CHANGED_BIT=4, EDGE_RISING=1, TIMESTAMP={1,6'd4}=68.
- Hold 1s, then word 0x0000_0000_0000_0001 (falls at bit 1), EDGE_MODE=01 -> no flag. Repeat with EDGE_MODE=10 -> flag, CHANGED_BIT=1, EDGE_RISING=0.
- Alternating all-0 / all-1 words every cycle with EDGE_MODE=11 -> CHANGED_FLAG high every cycle, CHANGED_BIT=0, EDGE_RISING alternating.
- last_state=0, word 0x0000_0000_00F0_0000 -> no CHANGED_FLAG. GLITCH_FLAG=1 with the macro defined, 0 without.
- Preload word_counter near wrap (TS_BITS=8, WIDTH=16, counter 15 -> 0), edge at bit 9 on the wrap word -> TIMESTAMP=0x09.
- Edge word presented, RESET asserted for one cycle 2 cycles later -> no CHANGED_FLAG; outputs 0; word_counter restarts at 0.
